// File: rtl/core_tb_top.sv
// core_tb_top: single-issue 32-bit core with built-in program ROM that self-checks its result on HALT (ports: clk, rst, en)
module core_tb_top #(
  parameter int ROM_DEPTH = 64,
  parameter int TIMEOUT = 1000,
  parameter int PROGRAM = 0
) (
  input logic clk,
  input logic rst,
  input logic en
);
  logic [5:0] pc;
  logic [31:0] regs [0:15];
  logic halted, pass, fail;
  logic [15:0] retired, cycles;
  logic [31:0] inst, a, b, simm, res, tgt;
  logic [3:0] op, rd, rs1, rs2;
  logic [15:0] imm, cyc_nxt;
  logic [5:0] pc_nxt;
  logic wr, taken, is_halt, illegal, ck_pass, tmo;
  function automatic logic [31:0] rom(input logic [5:0] addr);
    if (32'(addr) >= 32'(ROM_DEPTH)) return 32'hF000_0000;
    if (PROGRAM == 1) return addr == 6'd0 ? 32'h8000_0000 : 32'hF000_0000;
    case (addr)
      6'd0: return 32'h6000_0007;
      6'd1: return 32'h6100_000A;
      6'd2: return 32'h6200_0000;
      6'd3: return 32'h1221_0000;
      6'd4: return 32'h6110_FFFF;
      6'd5: return 32'h9010_FFFE;
      default: return 32'hF000_0000;
    endcase
  endfunction
  always_comb begin
    inst = rom(pc);
    op = inst[31:28];
    rd = inst[27:24];
    rs1 = inst[23:20];
    rs2 = inst[19:16];
    imm = inst[15:0];
    simm = {{16{imm[15]}}, imm};
    a = regs[rs1];
    b = regs[rs2];
    res = op == 4'h1 ? a + b :
          op == 4'h2 ? a - b :
          op == 4'h3 ? a & b :
          op == 4'h4 ? a | b :
          op == 4'h5 ? a ^ b :
          op == 4'h6 ? a + simm :
          op == 4'h7 ? {imm, 16'h0} :
          {31'b0, $signed(a) < $signed(b)};
    wr = op inside {[4'h1:4'h7], 4'hA};
    taken = (op == 4'h8 && a == b) || (op == 4'h9 && a != b);
    tgt = taken ? 32'(pc) + simm : 32'(pc) + 32'd1;
    // modulo wraps both forward overrun and negative branch targets
    pc_nxt = 6'(tgt % 32'(ROM_DEPTH));
    is_halt = op == 4'hF;
    illegal = op inside {[4'hB:4'hE]};
    ck_pass = regs[2] == 32'd55 && regs[1] == 32'd0 && regs[0] == 32'd0;
    cyc_nxt = cycles + 16'd1;
    tmo = cyc_nxt == 16'(TIMEOUT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      halted <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      retired <= '0;
      cycles <= '0;
    end else if (en && !halted) begin
      cycles <= cyc_nxt;
      if (is_halt) begin
        halted <= 1'b1;
        pass <= ck_pass;
        fail <= !ck_pass;
        if (ck_pass) $display("CORE_TB PASS");
        else $display("CORE_TB FAIL r1=%0d r2=%0d", regs[1], regs[2]);
      end else if (illegal) begin
        halted <= 1'b1;
        fail <= 1'b1;
        $display("CORE_TB FAIL illegal op at pc=%0d", pc);
      end else begin
        pc <= pc_nxt;
        retired <= retired + 16'd1;
        if (wr && rd != 4'd0) regs[rd] <= res;
        if (tmo) begin
          halted <= 1'b1;
          fail <= 1'b1;
          $display("CORE_TB TIMEOUT");
        end
      end
    end
  end
endmodule

// File: tb/tb_core_tb_top.sv
// tb_core_tb_top: self-checking bench for core_tb_top (sum program and timeout program)
module tb_core_tb_top;
  logic clk = 1'b0;
  logic rst, en0, en1;
  int tests = 0;
  int failed = 0;
  typedef struct {
    int pc;
    int r;
    logic [31:0] val;
  } vec_t;
  vec_t vecs [5];
  vec_t sbq [$];
  vec_t e;
  int edges;
  always #5 clk = ~clk;
  core_tb_top #(.ROM_DEPTH(64), .TIMEOUT(1000), .PROGRAM(0)) u0 (.clk(clk), .rst(rst), .en(en0));
  core_tb_top #(.ROM_DEPTH(64), .TIMEOUT(20), .PROGRAM(1)) u1 (.clk(clk), .rst(rst), .en(en1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_idle(input string n);
    chk({n, " pc"}, 32'(u0.pc), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("%s r%0d", n, i), u0.regs[i], 0);
    chk({n, " halted"}, 32'(u0.halted), 0);
    chk({n, " pass"}, 32'(u0.pass), 0);
    chk({n, " fail"}, 32'(u0.fail), 0);
    chk({n, " retired"}, 32'(u0.retired), 0);
    chk({n, " cycles"}, 32'(u0.cycles), 0);
    chk({n, " u1 cycles"}, 32'(u1.cycles), 0);
  endtask
  task automatic run_to_halt(input bit toggle, output int n);
    n = 0;
    for (int c = 0; c < 200 && !u0.halted; c++) begin
      en0 = toggle ? ~c[0] : 1'b1;
      step();
      if (en0) n++;
    end
    en0 = 1'b0;
    tests++;
    if (!u0.halted) begin
      failed++;
      $display("FAIL run_to_halt: halted=%0b after cycle budget, expected 1", u0.halted);
    end
  endtask
  task automatic chk_done(input string n, input int ed);
    chk({n, " edges"}, 32'(ed), 34);
    chk({n, " r2"}, u0.regs[2], 55);
    chk({n, " r1"}, u0.regs[1], 0);
    chk({n, " r0"}, u0.regs[0], 0);
    chk({n, " retired"}, 32'(u0.retired), 33);
    chk({n, " cycles"}, 32'(u0.cycles), 34);
    chk({n, " pass"}, 32'(u0.pass), 1);
    chk({n, " fail"}, 32'(u0.fail), 0);
  endtask
  initial begin
    vecs[0] = '{pc: 1, r: 0, val: 32'd0};
    vecs[1] = '{pc: 2, r: 1, val: 32'd10};
    vecs[2] = '{pc: 3, r: 2, val: 32'd0};
    vecs[3] = '{pc: 4, r: 2, val: 32'd10};
    vecs[4] = '{pc: 5, r: 1, val: 32'd9};
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk_idle("reset");
    repeat (10) step();
    chk_idle("en0 hold");
    for (int i = 0; i < 5; i++) begin
      en0 = 1'b1;
      sbq.push_back(vecs[i]);
      step();
      e = sbq.pop_front();
      chk($sformatf("edge%0d pc", i + 1), 32'(u0.pc), 32'(e.pc));
      chk($sformatf("edge%0d r%0d", i + 1, e.r), u0.regs[e.r], e.val);
      chk($sformatf("edge%0d retired", i + 1), 32'(u0.retired), 32'(i + 1));
    end
    run_to_halt(1'b0, edges);
    chk_done("cont", edges + 5);
    en0 = 1'b1;
    repeat (5) step();
    en0 = 1'b0;
    chk("frozen cycles", 32'(u0.cycles), 34);
    chk("frozen pc", 32'(u0.pc), 6);
    chk("frozen pass", 32'(u0.pass), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst2");
    run_to_halt(1'b1, edges);
    chk_done("toggle", edges);
    rst = 1'b1;
    step();
    rst = 1'b0;
    en0 = 1'b1;
    repeat (10) step();
    chk("mid retired", 32'(u0.retired), 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst pc", 32'(u0.pc), 0);
    chk("midrst r2", u0.regs[2], 0);
    chk("midrst r1", u0.regs[1], 0);
    chk("midrst retired", 32'(u0.retired), 0);
    chk("midrst cycles", 32'(u0.cycles), 0);
    run_to_halt(1'b0, edges);
    chk_done("midrst", edges);
    rst = 1'b1;
    step();
    rst = 1'b0;
    en1 = 1'b1;
    repeat (19) step();
    chk("tmo19 halted", 32'(u1.halted), 0);
    chk("tmo19 cycles", 32'(u1.cycles), 19);
    step();
    chk("tmo20 halted", 32'(u1.halted), 1);
    chk("tmo20 fail", 32'(u1.fail), 1);
    chk("tmo20 pass", 32'(u1.pass), 0);
    chk("tmo20 pc", 32'(u1.pc), 0);
    chk("tmo20 cycles", 32'(u1.cycles), 20);
    repeat (3) step();
    chk("tmo frozen cycles", 32'(u1.cycles), 20);
    chk("tmo frozen fail", 32'(u1.fail), 1);
    en1 = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
